mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the fetch stage (instruction reads) and the memory-access stage (data loads/stores) of the 5-stage core.
- Sequences each transaction with a 3-state FSM and registers address/data toward the memory.
- Returns read data and a one-cycle done pulse to the requester.
- Generates per-stage stall signals that the pipeline boundaries use to hold.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
BE_W, 4, byte-enable width (DATA_W/8)

Ports:
CLK  in  1  clock
RESET  in  1  reset; synchronous, active-high
I_REQ  in  1  fetch request; held with stable I_ADDR until I_DONE
I_ADDR  in  ADDR_W  fetch address
I_FLUSH  in  1  discard any fetch in flight (taken branch/jump)
I_DONE  out  1  one-cycle pulse: I_RDATA valid
I_RDATA  out  DATA_W  instruction word
D_REQ  in  1  data request; held with stable D_* until D_DONE
D_WE  in  1  1=store, 0=load
D_ADDR  in  ADDR_W  data address
D_WDATA  in  DATA_W  store data
D_BE  in  BE_W  byte enables
D_DONE  out  1  one-cycle pulse: load data valid / store complete
D_RDATA  out  DATA_W  load data
STALL_IF  out  1  = I_REQ & ~I_DONE (combinational)
STALL_MEM  out  1  = D_REQ & ~D_DONE (combinational)
MEM_REQ  out  1  request to memory; held until MEM_ACK
MEM_WE  out  1  write enable
MEM_ADDR  out  ADDR_W  registered address
MEM_WDATA  out  DATA_W  registered write data
MEM_BE  out  BE_W  registered byte enables (all ones for fetch)
MEM_ACK  in  1  memory completion pulse; MEM_RDATA valid same cycle
MEM_RDATA  in  DATA_W  memory read data

Behaviour:
- Reset values:
  - State IDLE; last_grant = FETCH.
  - MEM_REQ, MEM_WE, I_DONE, D_DONE all 0.
  - MEM_ADDR, MEM_WDATA, I_RDATA, D_RDATA all 0; MEM_BE 0.
  - flush_pend 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- Arbitration, evaluated in IDLE and on the MEM_ACK cycle of either BUSY state:
  - Data wins by default.
  - Exception: if last_grant == DATA and I_REQ is pending, fetch wins (anti-starvation alternation).
  - A requester whose DONE pulses this same cycle is not pending.
- Grant actions:
  - Register MEM_ADDR, MEM_WE, MEM_WDATA and MEM_BE from the winner.
  - Set MEM_REQ=1 on the next cycle.
  - Go to BUSY_I or BUSY_D and update last_grant.
  - Fetch grants drive MEM_WE=0 and MEM_BE all ones.
- Latency: a request sampled in IDLE at edge t gives MEM_REQ high after edge t. MEM_ACK at the earliest in that cycle gives DONE high after edge t+1. Minimum request-to-DONE is 2 cycles.
- On MEM_ACK in BUSY_x:
  - Capture MEM_RDATA into x_RDATA (D_RDATA holds its previous value for stores).
  - Pulse x_DONE for exactly one cycle.
  - If another request is pending, re-grant in the same cycle: back-to-back with no idle cycle, MEM_REQ stays high, new address loaded. Otherwise drop MEM_REQ and return to IDLE.
- MEM_ACK while in IDLE is ignored.
- Flush:
  - I_FLUSH in BUSY_I sets flush_pend. The transaction still waits for MEM_ACK. On that ACK, I_DONE is suppressed, I_RDATA is unchanged, and flush_pend clears.
  - I_FLUSH in IDLE or BUSY_D has no effect beyond that cycle.
  - I_FLUSH and MEM_ACK in the same BUSY_I cycle: the result is discarded.
- Requester rules:
  - x_REQ low before DONE means the request is withdrawn. An ungranted withdrawal is harmless.
  - A granted transaction completes regardless, and its DONE is still pulsed.
- Reset mid-operation: everything returns to the reset values on the next edge and MEM_REQ drops. The memory is required to drop any in-flight access on RESET.
- Only one memory transaction is outstanding at any time.
- Widths are passed through unmodified. No address alignment checks are made.

Test Plan:
- Fetch only: I_REQ=1, I_ADDR=0x100, MEM_ACK one cycle after MEM_REQ with MEM_RDATA=0x00500093 -> MEM_ADDR=0x100, MEM_WE=0, MEM_BE=0xF; I_DONE pulses 2 cycles after request with I_RDATA=0x00500093; STALL_IF high for exactly 2 cycles.
- Simultaneous, equal start: I_REQ (0x104) and D_REQ load (0x2000) in IDLE with last_grant=FETCH -> data granted first. On its ACK, fetch is granted back-to-back with MEM_REQ continuously high. D_DONE precedes I_DONE by one ACK.
- Anti-starvation: D_REQ stays asserted for 3 successive stores (0x2000, 0x2004, 0x2008) while I_REQ is held at 0x108 -> grant order D, I, D, I, D; no requester waits more than one transaction.
- Store: D_WE=1, D_ADDR=0x3000, D_WDATA=0xDEADBEEF, D_BE=0x3 -> MEM_WE=1, MEM_WDATA=0xDEADBEEF, MEM_BE=0x3; D_DONE pulses; D_RDATA unchanged.
- Flush: fetch 0x10C in BUSY_I, I_FLUSH pulsed before MEM_ACK (ACK data 0x12345678) -> no I_DONE, I_RDATA unchanged. A subsequent fetch 0x200 completes normally.
- Reset mid-transaction: RESET during BUSY_D, followed by a stray MEM_ACK -> MEM_REQ=0 after the reset edge, no D_DONE, state IDLE; the next D_REQ is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory handshake signals of the shared memory port.
// No logic and no latency; it only carries wires between requesters, arbiter and memory.
// Backpressure is expressed by the REQ/DONE and MEM_REQ/MEM_ACK pairs it carries.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  // fetch stage
  logic              I_REQ;
  logic [ADDR_W-1:0] I_ADDR;
  logic              I_FLUSH;
  logic              I_DONE;
  logic [DATA_W-1:0] I_RDATA;
  // memory-access stage
  logic              D_REQ;
  logic              D_WE;
  logic [ADDR_W-1:0] D_ADDR;
  logic [DATA_W-1:0] D_WDATA;
  logic [BE_W-1:0]   D_BE;
  logic              D_DONE;
  logic [DATA_W-1:0] D_RDATA;
  // pipeline hold signals
  logic              STALL_IF;
  logic              STALL_MEM;
  // unified memory
  logic              MEM_REQ;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [BE_W-1:0]   MEM_BE;
  logic              MEM_ACK;
  logic [DATA_W-1:0] MEM_RDATA;

  // arbiter view
  modport slave (
    input  I_REQ, I_ADDR, I_FLUSH,
    input  D_REQ, D_WE, D_ADDR, D_WDATA, D_BE,
    input  MEM_ACK, MEM_RDATA,
    output I_DONE, I_RDATA, D_DONE, D_RDATA,
    output STALL_IF, STALL_MEM,
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE
  );

  // requester + memory view
  modport master (
    output I_REQ, I_ADDR, I_FLUSH,
    output D_REQ, D_WE, D_ADDR, D_WDATA, D_BE,
    output MEM_ACK, MEM_RDATA,
    input  I_DONE, I_RDATA, D_DONE, D_RDATA,
    input  STALL_IF, STALL_MEM,
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access, one access at a time.
// Latency: request in IDLE -> MEM_REQ next cycle; MEM_ACK -> DONE pulse next cycle (2 cycles minimum).
// Backpressure: STALL_x holds a stage until its DONE; MEM_REQ is held until MEM_ACK.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    G_FETCH = 1'b0,
    G_DATA  = 1'b1
  } grant_t;

  state_t            state_q;
  grant_t            last_grant_q;
  logic              flush_pend_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;
  logic              i_done_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic              d_done_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic ack_i;
  logic ack_d;
  logic flushed;
  logic i_pend;
  logic d_pend;
  logic arb_en;
  logic gnt_data_d;
  logic gnt_fetch_d;

  // Arbitration: a requester that is completing now, or whose DONE is showing,
  // still has REQ high with its old address, so it must not be re-granted.
  // A flushed fetch produces no DONE, so a new fetch may be granted on its ACK.
  always_comb begin
    ack_i       = (state_q == BUSY_I) & bus.MEM_ACK;
    ack_d       = (state_q == BUSY_D) & bus.MEM_ACK;
    flushed     = flush_pend_q | bus.I_FLUSH;
    i_pend      = bus.I_REQ & ~i_done_q & ~(ack_i & ~flushed);
    d_pend      = bus.D_REQ & ~d_done_q & ~ack_d;
    arb_en      = (state_q == IDLE) | ack_i | ack_d;
    gnt_data_d  = arb_en & d_pend & ~((last_grant_q == G_DATA) & i_pend);
    gnt_fetch_d = arb_en & i_pend & ~gnt_data_d;
  end

  // Transaction FSM with all memory-side and requester-side outputs registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= G_FETCH;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      i_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_done_q     <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;

      // fetch completion, discarded when a flush was seen during the access
      if (ack_i) begin
        if (!flushed) begin
          i_done_q  <= 1'b1;
          i_rdata_q <= bus.MEM_RDATA;
        end
        flush_pend_q <= 1'b0;
      end else if ((state_q == BUSY_I) && bus.I_FLUSH) begin
        flush_pend_q <= 1'b1;
      end

      // data completion; stores leave the load data register untouched
      if (ack_d) begin
        d_done_q <= 1'b1;
        if (!mem_we_q) begin
          d_rdata_q <= bus.MEM_RDATA;
        end
      end

      // new grant (possibly back-to-back on an ACK) or return to idle
      if (gnt_data_d) begin
        state_q      <= BUSY_D;
        last_grant_q <= G_DATA;
        mem_req_q    <= 1'b1;
        mem_we_q     <= bus.D_WE;
        mem_addr_q   <= bus.D_ADDR;
        mem_wdata_q  <= bus.D_WDATA;
        mem_be_q     <= bus.D_BE;
      end else if (gnt_fetch_d) begin
        state_q      <= BUSY_I;
        last_grant_q <= G_FETCH;
        mem_req_q    <= 1'b1;
        mem_we_q     <= 1'b0;
        mem_addr_q   <= bus.I_ADDR;
        mem_be_q     <= {BE_W{1'b1}};
      end else if (ack_i || ack_d) begin
        state_q   <= IDLE;
        mem_req_q <= 1'b0;
      end
    end
  end

  assign bus.MEM_REQ   = mem_req_q;
  assign bus.MEM_WE    = mem_we_q;
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.MEM_WDATA = mem_wdata_q;
  assign bus.MEM_BE    = mem_be_q;
  assign bus.I_DONE    = i_done_q;
  assign bus.I_RDATA   = i_rdata_q;
  assign bus.D_DONE    = d_done_q;
  assign bus.D_RDATA   = d_rdata_q;
  assign bus.STALL_IF  = bus.I_REQ & ~i_done_q;
  assign bus.STALL_MEM = bus.D_REQ & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Exercises the memory port arbiter against a behavioural memory and a scoreboard.
// Expected grants and read data are queued when stimulus is issued, checked on ACK/DONE.
// The memory model acknowledges after a programmable number of wait cycles.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } grant_s;

  grant_s      exp_grant[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural memory
  logic [31:0] mem [logic [31:0]];
  bit          mem_en    = 1'b1;
  bit          stray_req = 1'b0;
  int          mem_lat   = 0;
  int          wait_cnt  = 0;
  logic [31:0] d_model   = '0;

  function automatic logic [31:0] memread(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic serve();
    grant_s      g;
    logic [31:0] w;
    if (exp_grant.size() == 0) begin
      chk("grant_unexpected", 1, 0);
    end else begin
      g = exp_grant.pop_front();
      chk("mem_addr", bus.MEM_ADDR, g.addr);
      chk("mem_we", bus.MEM_WE, g.we);
      chk("mem_be", bus.MEM_BE, g.be);
      if (g.we) chk("mem_wdata", bus.MEM_WDATA, g.wdata);
    end
    if (bus.MEM_WE) begin
      w = memread(bus.MEM_ADDR);
      for (int b = 0; b < 4; b++)
        if (bus.MEM_BE[b]) w[8*b +: 8] = bus.MEM_WDATA[8*b +: 8];
      mem[bus.MEM_ADDR] = w;
    end else begin
      bus.MEM_RDATA = memread(bus.MEM_ADDR);
    end
  endtask

  initial begin
    bus.MEM_ACK   = 1'b0;
    bus.MEM_RDATA = '0;
    forever begin
      @(posedge CLK); #1;
      bus.MEM_ACK = 1'b0;
      if (stray_req) begin
        stray_req     = 1'b0;
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 32'hBAD0_BAD0;
      end else if (mem_en && bus.MEM_REQ && !RESET) begin
        if (wait_cnt >= mem_lat) begin
          wait_cnt    = 0;
          bus.MEM_ACK = 1'b1;
          serve();
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // output monitor
  int cyc = 0, stall_if_cycles = 0, req_rises = 0, i_done_at = 0, d_done_at = 0;
  logic req_prev = 1'b0, i_done_prev = 1'b0, d_done_prev = 1'b0;

  initial begin
    forever begin
      @(negedge CLK);
      chk("stall_if", bus.STALL_IF, bus.I_REQ & ~bus.I_DONE);
      chk("stall_mem", bus.STALL_MEM, bus.D_REQ & ~bus.D_DONE);
      if (bus.STALL_IF) stall_if_cycles++;
      if (bus.MEM_REQ === 1'b1 && !req_prev) req_rises++;
      if (bus.I_DONE === 1'b1) begin
        chk("i_done_pulse", i_done_prev, 0);
        if (exp_i.size() == 0) chk("i_done_unexpected", 1, 0);
        else chk("i_rdata", bus.I_RDATA, exp_i.pop_front());
        i_done_at = cyc;
      end
      if (bus.D_DONE === 1'b1) begin
        chk("d_done_pulse", d_done_prev, 0);
        if (exp_d.size() == 0) chk("d_done_unexpected", 1, 0);
        else chk("d_rdata", bus.D_RDATA, exp_d.pop_front());
        d_done_at = cyc;
      end
      req_prev    = (bus.MEM_REQ === 1'b1);
      i_done_prev = (bus.I_DONE === 1'b1);
      d_done_prev = (bus.D_DONE === 1'b1);
      cyc++;
    end
  end

  task automatic push_grant(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be);
    grant_s g;
    g.addr = a; g.we = we; g.wdata = wd; g.be = be;
    exp_grant.push_back(g);
  endtask

  task automatic fetch(input logic [31:0] a, output int lat);
    exp_i.push_back(memread(a));
    bus.I_REQ  = 1'b1;
    bus.I_ADDR = a;
    lat = 0;
    while (1) begin
      @(posedge CLK); #1;
      lat++;
      if (bus.I_DONE) break;
      if (lat > 200) begin chk("fetch_timeout", 1, 0); break; end
    end
    @(posedge CLK); #1;
    bus.I_REQ = 1'b0;
  endtask

  task automatic data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output int lat);
    if (!we) d_model = memread(a);
    exp_d.push_back(d_model);
    bus.D_REQ   = 1'b1;
    bus.D_WE    = we;
    bus.D_ADDR  = a;
    bus.D_WDATA = wd;
    bus.D_BE    = be;
    lat = 0;
    while (1) begin
      @(posedge CLK); #1;
      lat++;
      if (bus.D_DONE) break;
      if (lat > 200) begin chk("data_timeout", 1, 0); break; end
    end
    @(posedge CLK); #1;
    bus.D_REQ = 1'b0;
  endtask

  task automatic do_reset();
    chk("queues_drained", exp_grant.size() + exp_i.size() + exp_d.size(), 0);
    exp_grant.delete(); exp_i.delete(); exp_d.delete();
    RESET = 1'b1;
    bus.I_REQ = 1'b0; bus.I_FLUSH = 1'b0; bus.D_REQ = 1'b0;
    mem_en = 1'b1; mem_lat = 0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    d_model = '0;
    stall_if_cycles = 0;
    req_rises = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int l1, l2;

  initial begin
    RESET = 1'b1;
    bus.I_REQ = 1'b0; bus.I_ADDR = '0; bus.I_FLUSH = 1'b0;
    bus.D_REQ = 1'b0; bus.D_WE = 1'b0; bus.D_ADDR = '0; bus.D_WDATA = '0; bus.D_BE = '0;
    mem[32'h100] = 32'h0050_0093;
    mem[32'h10C] = 32'h1234_5678;

    // reset values and a single fetch
    do_reset();
    chk("rst_mem_req", bus.MEM_REQ, 0);
    chk("rst_mem_we", bus.MEM_WE, 0);
    chk("rst_mem_addr", bus.MEM_ADDR, 0);
    chk("rst_mem_wdata", bus.MEM_WDATA, 0);
    chk("rst_mem_be", bus.MEM_BE, 0);
    chk("rst_i_done", bus.I_DONE, 0);
    chk("rst_d_done", bus.D_DONE, 0);
    chk("rst_i_rdata", bus.I_RDATA, 0);
    chk("rst_d_rdata", bus.D_RDATA, 0);
    push_grant(32'h100, 1'b0, 32'h0, 4'hF);
    fetch(32'h100, l1);
    chk("fetch_latency", l1, 2);
    chk("stall_if_cycles", stall_if_cycles, 2);

    // simultaneous start: data first, fetch back-to-back
    do_reset();
    push_grant(32'h2000, 1'b0, 32'h0, 4'hF);
    push_grant(32'h104, 1'b0, 32'h0, 4'hF);
    fork
      fetch(32'h104, l1);
      data(1'b0, 32'h2000, 32'h0, 4'hF, l2);
    join
    chk("b2b_req_rises", req_rises, 1);
    chk("d_before_i", i_done_at - d_done_at, 1);

    // alternation with both requesters streaming
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_grant(32'h2000 + 32'(4 * k), 1'b1, 32'hA000_0000 + 32'(k), 4'hF);
      push_grant(32'h108, 1'b0, 32'h0, 4'hF);
    end
    fork
      begin
        int ld;
        for (int k = 0; k < 3; k++) data(1'b1, 32'h2000 + 32'(4 * k), 32'hA000_0000 + 32'(k), 4'hF, ld);
      end
      begin
        int lf;
        for (int k = 0; k < 3; k++) fetch(32'h108, lf);
      end
    join

    // fetch wins a tie when data had the previous grant
    do_reset();
    push_grant(32'h2010, 1'b0, 32'h0, 4'hF);
    data(1'b0, 32'h2010, 32'h0, 4'hF, l2);
    push_grant(32'h114, 1'b0, 32'h0, 4'hF);
    push_grant(32'h2014, 1'b0, 32'h0, 4'hF);
    fork
      fetch(32'h114, l1);
      data(1'b0, 32'h2014, 32'h0, 4'hF, l2);
    join
    chk("i_before_d", d_done_at - i_done_at, 1);

    // load then partial store with wait states
    do_reset();
    mem_lat = 2;
    push_grant(32'h3000, 1'b0, 32'h0, 4'hF);
    data(1'b0, 32'h3000, 32'h0, 4'hF, l2);
    chk("load_latency_ws", l2, 4);
    push_grant(32'h3000, 1'b1, 32'hDEAD_BEEF, 4'h3);
    data(1'b1, 32'h3000, 32'hDEAD_BEEF, 4'h3, l2);
    chk("store_mem", memread(32'h3000), 32'h5A5A_BEEF);

    // flush before ACK, flush on ACK, then a normal fetch
    do_reset();
    push_grant(32'h100, 1'b0, 32'h0, 4'hF);
    fetch(32'h100, l1);
    mem_lat = 3;
    push_grant(32'h10C, 1'b0, 32'h0, 4'hF);
    bus.I_REQ = 1'b1; bus.I_ADDR = 32'h10C;
    @(posedge CLK); #1;
    chk("flush_busy", bus.MEM_REQ, 1);
    bus.I_FLUSH = 1'b1; bus.I_REQ = 1'b0;
    @(posedge CLK); #1;
    bus.I_FLUSH = 1'b0;
    for (int n = 0; n < 20 && bus.MEM_REQ; n++) begin @(posedge CLK); #1; end
    chk("flush_req_drop", bus.MEM_REQ, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("flush_rdata_hold", bus.I_RDATA, 32'h0050_0093);
    mem_lat = 0;
    push_grant(32'h110, 1'b0, 32'h0, 4'hF);
    bus.I_REQ = 1'b1; bus.I_ADDR = 32'h110;
    @(posedge CLK); #1;
    bus.I_FLUSH = 1'b1; bus.I_REQ = 1'b0;
    @(posedge CLK); #1;
    bus.I_FLUSH = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("flush_ack_rdata_hold", bus.I_RDATA, 32'h0050_0093);
    push_grant(32'h200, 1'b0, 32'h0, 4'hF);
    fetch(32'h200, l1);
    chk("post_flush_latency", l1, 2);

    // reset during a data access, then a stray ACK
    do_reset();
    mem_en = 1'b0;
    bus.D_REQ = 1'b1; bus.D_WE = 1'b0; bus.D_ADDR = 32'h2400; bus.D_BE = 4'hF;
    @(posedge CLK); #1;
    chk("rst_busy_req", bus.MEM_REQ, 1);
    RESET = 1'b1; bus.D_REQ = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("midrst_mem_req", bus.MEM_REQ, 0);
    chk("midrst_mem_addr", bus.MEM_ADDR, 0);
    chk("midrst_d_done", bus.D_DONE, 0);
    stray_req = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("stray_mem_req", bus.MEM_REQ, 0);
    chk("stray_d_rdata", bus.D_RDATA, 0);
    mem_en = 1'b1;
    push_grant(32'h2400, 1'b0, 32'h0, 4'hF);
    data(1'b0, 32'h2400, 32'h0, 4'hF, l2);
    chk("post_rst_latency", l2, 2);

    repeat (3) @(posedge CLK);
    #1;
    chk("grant_queue_empty", exp_grant.size(), 0);
    chk("i_queue_empty", exp_i.size(), 0);
    chk("d_queue_empty", exp_d.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
